uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter among N byte-stream requesters.
- Each requester offers bytes on a valid/ready handshake.
- The block latches the winning byte, pulses the transmitter's start strobe, tracks its busy flag through the frame, and enforces an optional inter-frame guard gap.
- Sits between the peripheral bus masters (CPU console, debug, trace) and the UART transmitter.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- GUARD_CYCLES, 0, idle clocks inserted after busy falls, before the next grant (0..255).
- ID_W, $clog2(NUM_REQ), width of the grant index.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  reset, asynchronous, active-low.
- Enable  in  1  1 allows new grants. 0 blocks grants only; an in-flight frame completes.
- ReqValid  in  NUM_REQ  per-requester byte available.
- ReqData  in  NUM_REQ*8  requester i byte at bits [8i+7:8i].
- ReqReady  out  NUM_REQ  one-hot accept; the byte is consumed in the cycle Valid&Ready is high.
- TxStart  out  1  one-cycle start strobe to the transmitter.
- TxData  out  8  byte to the transmitter; valid while TxStart is high.
- TxBusy  in  1  transmitter busy flag.
- GrantId  out  ID_W  index of the requester that owns the current frame.
- Active  out  1  high from accept until return to IDLE.

Behaviour:
- Reset values: ReqReady=0, TxStart=0, TxData=0, GrantId=0, Active=0, state=S_IDLE, priority pointer=0, guard counter=0.
- FSM states: S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_WAIT_DONE, S_GUARD.
- S_IDLE:
  - ReqReady is combinational: one-hot for the first valid requester searching upward from the pointer, modulo NUM_REQ, gated by Enable.
  - On accept at cycle t: register ReqData of the winner into TxData, set GrantId, set Active=1, pointer <= winner+1 (wraps to 0 after NUM_REQ-1), go to S_LAUNCH.
- S_LAUNCH:
  - TxStart=1 for exactly this cycle (t+1).
  - Go to S_WAIT_BUSY.
- S_WAIT_BUSY:
  - The transmitter raises TxBusy the cycle after the strobe (t+2).
  - On TxBusy=1, go to S_WAIT_DONE.
  - If TxBusy is still 0 after 4 cycles in this state, re-pulse TxStart once and restart the 4-cycle window. The transmitter was idle, so a repeat strobe is harmless.
- S_WAIT_DONE:
  - On TxBusy=0 (cycle d): if GUARD_CYCLES=0, go to S_IDLE at d+1.
  - Otherwise load the guard counter with GUARD_CYCLES-1 and go to S_GUARD.
- S_GUARD:
  - Decrement the counter each cycle.
  - At 0, go to S_IDLE; IDLE is reached GUARD_CYCLES cycles after d+1.
- Active:
  - Set in the accept cycle (registered, so high from t+1).
  - Cleared on entry to S_IDLE.
  - Earliest next accept is the cycle IDLE is re-entered.
- TxData and GrantId hold their value until the next accept.
- Simultaneous valids: only one ReqReady per accept. Losers wait; their ReqValid and ReqData must stay stable.
- A requester dropping ReqValid before ready is allowed; it is simply not granted.
- Enable=0 while in IDLE: ReqReady=0. Enable does not affect the other states.
- Reset asserted mid-frame:
  - Returns immediately to reset values; no TxStart is issued.
  - The transmitter shares the same reset, so both sides are idle together.
- TxBusy=1 seen while in S_IDLE or S_GUARD: ignored, no error path.

Decomposition:
- Shared package uart_pkg holds:
  - typedef enum uart_arb_state_t.
  - Constants UART_BYTE_W=8 and ARB_BUSY_TIMEOUT=4.
- One sub-module is natural: rr_pick.
  - Combinational round-robin selector: inputs request vector, pointer, enable.
  - Outputs one-hot grant and index.
  - Reusable by other shared peripherals.

Test Plan (NUM_REQ=4, GUARD_CYCLES=2 unless stated; transmitter model asserts TxBusy 1 cycle after TxStart, holds it 20 cycles):
- Single request: ReqValid[2]=1, ReqData[2]=0x5A at cycle 10 -> ReqReady=0100 at 10, TxStart=1 and TxData=0x5A at 11 only, GrantId=2, Active=1 from 11, IDLE re-entered 2 cycles after TxBusy falls.
- Fairness: all four valid continuously, pointer=0 -> grant order 0,1,2,3,0 across consecutive frames; exactly one TxStart per frame.
- Pointer wrap with sparse requests: only requesters 3 and 1 valid, pointer=2 -> grants 3 then 1; pointer ends at 2.
- Guard=0 build: back-to-back frames from requester 0 -> next ReqReady in the first cycle after TxBusy falls.
- Enable=0 mid-frame: frame in flight completes with normal timing; no ReqReady while Enable=0; grant occurs the cycle Enable returns to 1 in IDLE.
- Missing busy: model ignores the first strobe -> second TxStart 4 cycles later with the same TxData; frame then completes normally. Async reset pulse during S_WAIT_DONE -> all outputs 0 within the reset, state S_IDLE.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
package uart_pkg;

   localparam int UART_BYTE_W      = 8;
   localparam int ARB_BUSY_TIMEOUT = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_BUSY,
      S_WAIT_DONE,
      S_GUARD
   } uart_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: grants the first asserted request found
// searching upward from the pointer, wrapping past the top requester.
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] request,
   input  logic [ID_W-1:0]    pointer,
   input  logic               enable,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    index,
   output logic               found
);

   localparam logic [ID_W:0] REQ_COUNT = (ID_W+1)'(NUM_REQ);

   logic [ID_W:0]   sum;
   logic [ID_W-1:0] cand;

   // One extra bit on the sum lets the wrap be a single conditional subtract,
   // which also works when NUM_REQ is not a power of two.
   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, pointer} + (ID_W+1)'(k);
         if (sum >= REQ_COUNT) begin
            sum = sum - REQ_COUNT;
         end
         cand = sum[ID_W-1:0];
         if (enable && !found && request[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            index       = cand;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among several byte-stream requesters in round-robin
// order, following the transmitter busy flag and holding an optional guard gap.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int GUARD_CYCLES = 0,
   parameter int ID_W         = $clog2(NUM_REQ)
) (
   input  logic                           Clock,
   input  logic                           Reset,
   input  logic                           Enable,
   input  logic [NUM_REQ-1:0]             ReqValid,
   input  logic [NUM_REQ*UART_BYTE_W-1:0] ReqData,
   output logic [NUM_REQ-1:0]             ReqReady,
   output logic                           TxStart,
   output logic [UART_BYTE_W-1:0]         TxData,
   input  logic                           TxBusy,
   output logic [ID_W-1:0]                GrantId,
   output logic                           Active
);

   localparam int                 TIMER_W    = $clog2(ARB_BUSY_TIMEOUT);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(ARB_BUSY_TIMEOUT - 1);
   localparam logic [7:0]         GUARD_LOAD = 8'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
   localparam logic [ID_W-1:0]    LAST_ID    = ID_W'(NUM_REQ - 1);

   uart_arb_state_t        state;
   uart_arb_state_t        nextState;
   logic [ID_W-1:0]        pointer;
   logic [NUM_REQ-1:0]     pickGrant;
   logic [ID_W-1:0]        pickIndex;
   logic                   pickFound;
   logic                   pickEnable;
   logic [UART_BYTE_W-1:0] reqBytes [NUM_REQ];
   logic [TIMER_W-1:0]     busyTimer;
   logic                   busyTimeout;
   logic [7:0]             guardCnt;
   logic [UART_BYTE_W-1:0] txDataQ;
   logic [ID_W-1:0]        grantIdQ;
   logic                   activeQ;
   logic                   txStartComb;

   assign pickEnable = Enable && (state == S_IDLE);

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) picker (
      .request (ReqValid),
      .pointer (pointer),
      .enable  (pickEnable),
      .grant   (pickGrant),
      .index   (pickIndex),
      .found   (pickFound)
   );

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         reqBytes[i] = ReqData[i*UART_BYTE_W +: UART_BYTE_W];
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state <= S_IDLE;
      end else begin
         state <= nextState;
      end
   end

   // A transmitter that never raised busy was idle, so the strobe is simply
   // repeated on the last cycle of each wait window.
   always_comb begin
      nextState   = state;
      txStartComb = 1'b0;
      busyTimeout = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (pickFound) begin
               nextState = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            txStartComb = 1'b1;
            nextState   = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (TxBusy) begin
               nextState = S_WAIT_DONE;
            end else if (busyTimer == TIMER_LAST) begin
               txStartComb = 1'b1;
               busyTimeout = 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (!TxBusy) begin
               nextState = (GUARD_CYCLES == 0) ? S_IDLE : S_GUARD;
            end
         end
         S_GUARD: begin
            if (guardCnt == 8'd0) begin
               nextState = S_IDLE;
            end
         end
         default: begin
            nextState = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         pointer   <= '0;
         txDataQ   <= '0;
         grantIdQ  <= '0;
         activeQ   <= 1'b0;
         busyTimer <= '0;
         guardCnt  <= 8'd0;
      end else begin
         activeQ <= (nextState != S_IDLE);

         if (pickFound) begin
            txDataQ  <= reqBytes[pickIndex];
            grantIdQ <= pickIndex;
            pointer  <= (pickIndex == LAST_ID) ? '0 : pickIndex + ID_W'(1);
         end

         if (state == S_WAIT_BUSY && !TxBusy && !busyTimeout) begin
            busyTimer <= busyTimer + TIMER_W'(1);
         end else begin
            busyTimer <= '0;
         end

         if (state == S_WAIT_DONE && !TxBusy) begin
            guardCnt <= GUARD_LOAD;
         end else if (state == S_GUARD && guardCnt != 8'd0) begin
            guardCnt <= guardCnt - 8'd1;
         end
      end
   end

   assign ReqReady = pickGrant;
   assign TxStart  = txStartComb;
   assign TxData   = txDataQ;
   assign GrantId  = grantIdQ;
   assign Active   = activeQ;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table of single frames plus
// hand-written fairness, enable, guard-free, missing-busy and reset sequences.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
   import uart_pkg::*;

   localparam int NREQ = 4;
   localparam int HOLD = 20;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Enable = 1'b0;
   logic [3:0]  ReqValid = '0;
   logic [31:0] ReqData = '0;
   logic [3:0]  ReqReady;
   logic        TxStart;
   logic [7:0]  TxData;
   logic        TxBusy;
   logic [1:0]  GrantId;
   logic        Active;

   logic        enable0 = 1'b0;
   logic [3:0]  reqValid0 = '0;
   logic [31:0] reqData0 = '0;
   logic [3:0]  reqReady0;
   logic        txStart0;
   logic [7:0]  txData0;
   logic        txBusy0;
   logic [1:0]  grantId0;
   logic        active0;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   int         startCyc[$];
   logic [7:0] startData[$];
   logic [1:0] startId[$];
   int         acceptCyc[$];
   int         acceptCyc0[$];
   int         ignoreStrobe = -1;
   int         busyLeft;
   int         busyLeft0;

   uart_tx_arbiter #(.NUM_REQ(NREQ), .GUARD_CYCLES(2)) dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .ReqValid(ReqValid), .ReqData(ReqData),
      .ReqReady(ReqReady), .TxStart(TxStart), .TxData(TxData), .TxBusy(TxBusy),
      .GrantId(GrantId), .Active(Active)
   );

   uart_tx_arbiter #(.NUM_REQ(NREQ), .GUARD_CYCLES(0)) dut0 (
      .Clock(Clock), .Reset(Reset), .Enable(enable0), .ReqValid(reqValid0), .ReqData(reqData0),
      .ReqReady(reqReady0), .TxStart(txStart0), .TxData(txData0), .TxBusy(txBusy0),
      .GrantId(grantId0), .Active(active0)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cyc <= cyc + 1;

   // Transmitter model: busy from the cycle after an accepted strobe, for HOLD cycles.
   always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         TxBusy   <= 1'b0;
         busyLeft <= 0;
      end else if (busyLeft != 0) begin
         busyLeft <= busyLeft - 1;
         if (busyLeft == 1) TxBusy <= 1'b0;
      end else if (TxStart && (startCyc.size() - 1 != ignoreStrobe)) begin
         TxBusy   <= 1'b1;
         busyLeft <= HOLD;
      end
   end

   always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         txBusy0   <= 1'b0;
         busyLeft0 <= 0;
      end else if (busyLeft0 != 0) begin
         busyLeft0 <= busyLeft0 - 1;
         if (busyLeft0 == 1) txBusy0 <= 1'b0;
      end else if (txStart0) begin
         txBusy0   <= 1'b1;
         busyLeft0 <= HOLD;
      end
   end

   always @(negedge Clock) begin
      if (TxStart) begin
         startCyc.push_back(cyc);
         startData.push_back(TxData);
         startId.push_back(GrantId);
      end
      if (|(ReqReady & ReqValid)) acceptCyc.push_back(cyc);
      if (|(reqReady0 & reqValid0)) acceptCyc0.push_back(cyc);
   end

   typedef struct {
      logic        en;
      logic [3:0]  valid;
      logic [31:0] data;
      logic [3:0]  expReady;
      logic [1:0]  expId;
      logic [7:0]  expData;
      logic [1:0]  expPtr;
   } vec_t;

   vec_t vecs[12];

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic applyStimulus(input logic en, input logic [3:0] valid, input logic [31:0] data);
      Enable   = en;
      ReqValid = valid;
      ReqData  = data;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic doReset();
      Reset    = 1'b0;
      Enable   = 1'b0;
      ReqValid = '0;
      enable0  = 1'b0;
      reqValid0 = '0;
      repeat (3) tick();
      Reset = 1'b1;
      tick();
   endtask

   task automatic waitInactive(input string name, input int limit, output int endCyc);
      int n = 0;
      while (Active !== 1'b0 && n < limit) begin
         tick();
         n++;
      end
      if (Active !== 1'b0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: Active still 1 after %0d cycles, expected 0", name, limit);
      end
      endCyc = cyc;
   endtask

   initial begin
      int t, e, endC, base, n;

      vecs[0]  = '{1'b1, 4'b0100, 32'h005A0000, 4'b0100, 2'd2, 8'h5A, 2'd3};
      vecs[1]  = '{1'b1, 4'b1111, 32'h44332211, 4'b1000, 2'd3, 8'h44, 2'd0};
      vecs[2]  = '{1'b1, 4'b1111, 32'h88776655, 4'b0001, 2'd0, 8'h55, 2'd1};
      vecs[3]  = '{1'b1, 4'b1111, 32'hCCBBAA99, 4'b0010, 2'd1, 8'hAA, 2'd2};
      vecs[4]  = '{1'b1, 4'b1010, 32'h3C00C300, 4'b1000, 2'd3, 8'h3C, 2'd0};
      vecs[5]  = '{1'b1, 4'b0010, 32'h0000E100, 4'b0010, 2'd1, 8'hE1, 2'd2};
      vecs[6]  = '{1'b0, 4'b1111, 32'hFFFFFFFF, 4'b0000, 2'd0, 8'h00, 2'd2};
      vecs[7]  = '{1'b1, 4'b0001, 32'h000000D7, 4'b0001, 2'd0, 8'hD7, 2'd1};
      vecs[8]  = '{1'b1, 4'b1111, 32'h01020304, 4'b0010, 2'd1, 8'h03, 2'd2};
      vecs[9]  = '{1'b1, 4'b0011, 32'h00009F81, 4'b0001, 2'd0, 8'h81, 2'd1};
      vecs[10] = '{1'b1, 4'b0000, 32'h00000000, 4'b0000, 2'd0, 8'h00, 2'd1};
      vecs[11] = '{1'b1, 4'b1100, 32'h6B7C0000, 4'b0100, 2'd2, 8'h7C, 2'd3};

      #2 Reset = 1'b0;
      repeat (3) tick();
      checkOutput("reset ReqReady", 32'(ReqReady), 32'h0);
      checkOutput("reset TxStart", 32'(TxStart), 32'h0);
      checkOutput("reset TxData", 32'(TxData), 32'h0);
      checkOutput("reset GrantId", 32'(GrantId), 32'h0);
      checkOutput("reset Active", 32'(Active), 32'h0);
      checkOutput("reset state", 32'(dut.state), 32'(S_IDLE));
      checkOutput("reset pointer", 32'(dut.pointer), 32'h0);
      Reset = 1'b1;
      tick();

      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].en, vecs[i].valid, vecs[i].data);
         #1;
         checkOutput($sformatf("vec%0d ReqReady", i), 32'(ReqReady), 32'(vecs[i].expReady));
         if (vecs[i].expReady != 4'b0000) begin
            t    = cyc;
            base = startCyc.size();
            tick();
            ReqValid = '0;
            #1;
            checkOutput($sformatf("vec%0d TxStart", i), 32'(TxStart), 32'h1);
            checkOutput($sformatf("vec%0d TxData", i), 32'(TxData), 32'(vecs[i].expData));
            checkOutput($sformatf("vec%0d GrantId", i), 32'(GrantId), 32'(vecs[i].expId));
            checkOutput($sformatf("vec%0d Active", i), 32'(Active), 32'h1);
            tick();
            checkOutput($sformatf("vec%0d TxStart low", i), 32'(TxStart), 32'h0);
            waitInactive($sformatf("vec%0d frame", i), 60, endC);
            checkOutput($sformatf("vec%0d frame length", i), 32'(endC - t), 32'd25);
            checkOutput($sformatf("vec%0d strobes", i), 32'(startCyc.size() - base), 32'd1);
            checkOutput($sformatf("vec%0d pointer", i), 32'(dut.pointer), 32'(vecs[i].expPtr));
            checkOutput($sformatf("vec%0d TxData hold", i), 32'(TxData), 32'(vecs[i].expData));
         end else begin
            tick();
            ReqValid = '0;
         end
      end

      // Fairness: all requesters valid continuously from pointer 0.
      doReset();
      base = startCyc.size();
      applyStimulus(1'b1, 4'b1111, 32'hD3C2B1A0);
      n = 0;
      while (startCyc.size() < base + 5 && n < 200) begin
         tick();
         n++;
      end
      ReqValid = '0;
      waitInactive("fair drain", 60, endC);
      checkOutput("fair strobe count", 32'(startCyc.size() - base), 32'd5);
      if (startCyc.size() >= base + 5) begin
         for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("fair id%0d", k), 32'(startId[base+k]), 32'(k % 4));
            checkOutput($sformatf("fair data%0d", k), 32'(startData[base+k]), 32'(8'hA0 + 8'((k % 4) * 17)));
            if (k < 4) begin
               checkOutput($sformatf("fair gap%0d", k), 32'(startCyc[base+k+1] - startCyc[base+k]), 32'd25);
            end
         end
      end else begin
         checks++;
         errors++;
         $display("[TB] FAIL fair frames: got %0d strobes, expected 5", startCyc.size() - base);
      end

      // Enable dropped mid-frame: frame completes, no grants until re-enabled.
      doReset();
      applyStimulus(1'b1, 4'b0001, 32'h00000011);
      t = cyc;
      tick();
      applyStimulus(1'b0, 4'b0010, 32'h00002211);
      waitInactive("enable frame", 60, endC);
      checkOutput("enable frame length", 32'(endC - t), 32'd25);
      base = acceptCyc.size();
      for (int k = 0; k < 3; k++) begin
         checkOutput($sformatf("enable0 ReqReady%0d", k), 32'(ReqReady), 32'h0);
         tick();
      end
      checkOutput("enable0 no accept", 32'(acceptCyc.size() - base), 32'd0);
      Enable = 1'b1;
      e = cyc;
      #1;
      checkOutput("enable1 ReqReady", 32'(ReqReady), 32'b0010);
      tick();
      ReqValid = '0;
      checkOutput("enable1 accept count", 32'(acceptCyc.size() - base), 32'd1);
      if (acceptCyc.size() > base) checkOutput("enable1 accept cycle", 32'(acceptCyc[base]), 32'(e));
      checkOutput("enable1 TxStart", 32'(TxStart), 32'h1);
      checkOutput("enable1 GrantId", 32'(GrantId), 32'd1);
      checkOutput("enable1 TxData", 32'(TxData), 32'h22);
      waitInactive("enable1 frame", 60, endC);

      // Guard-free build: back-to-back frames from requester 0.
      doReset();
      base = acceptCyc0.size();
      enable0   = 1'b1;
      reqData0  = 32'h000000C4;
      reqValid0 = 4'b0001;
      n = 0;
      while (acceptCyc0.size() < base + 2 && n < 100) begin
         tick();
         n++;
      end
      reqValid0 = '0;
      if (acceptCyc0.size() >= base + 2) begin
         checkOutput("guard0 accept gap", 32'(acceptCyc0[base+1] - acceptCyc0[base]), 32'd23);
         checkOutput("guard0 TxData", 32'(txData0), 32'hC4);
      end else begin
         checks++;
         errors++;
         $display("[TB] FAIL guard0 accepts: got %0d, expected 2", acceptCyc0.size() - base);
      end

      // Missing busy: the first strobe is ignored by the transmitter.
      doReset();
      base = startCyc.size();
      ignoreStrobe = base;
      applyStimulus(1'b1, 4'b0010, 32'h00007700);
      t = cyc;
      tick();
      ReqValid = '0;
      n = 0;
      while (startCyc.size() < base + 2 && n < 20) begin
         tick();
         n++;
      end
      if (startCyc.size() >= base + 2) begin
         checkOutput("retry spacing", 32'(startCyc[base+1] - startCyc[base]), 32'd4);
         checkOutput("retry data", 32'(startData[base+1]), 32'h77);
      end else begin
         checks++;
         errors++;
         $display("[TB] FAIL retry strobe: got %0d strobes, expected 2", startCyc.size() - base);
      end
      waitInactive("retry frame", 60, endC);
      checkOutput("retry frame length", 32'(endC - t), 32'd29);
      checkOutput("retry strobes", 32'(startCyc.size() - base), 32'd2);

      // Asynchronous reset while the transmitter is busy.
      applyStimulus(1'b1, 4'b0100, 32'h00A50000);
      tick();
      ReqValid = '0;
      repeat (10) tick();
      checkOutput("midreset pre state", 32'(dut.state), 32'(S_WAIT_DONE));
      #2 Reset = 1'b0;
      #1;
      checkOutput("midreset TxStart", 32'(TxStart), 32'h0);
      checkOutput("midreset TxData", 32'(TxData), 32'h0);
      checkOutput("midreset GrantId", 32'(GrantId), 32'h0);
      checkOutput("midreset Active", 32'(Active), 32'h0);
      checkOutput("midreset state", 32'(dut.state), 32'(S_IDLE));
      checkOutput("midreset pointer", 32'(dut.pointer), 32'h0);
      tick();
      Reset = 1'b1;
      base = startCyc.size();
      repeat (5) tick();
      checkOutput("midreset no strobe", 32'(startCyc.size() - base), 32'd0);
      checkOutput("midreset idle Active", 32'(Active), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
